// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer that emits each N-sample frame in natural, bit-reversed,
// digit-reversed or half-swapped order, one output per input enable.
module fft_reorder_buf #(
    parameter int unsigned NB   = 12,
    parameter int unsigned LOGN = 8,
    parameter int unsigned LOGR = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          ED,
    input  logic [1:0]    MODE,
    input  logic [NB-1:0] DR,
    input  logic [NB-1:0] DI,
    output logic [NB-1:0] DOR,
    output logic [NB-1:0] DOI,
    output logic          VLD,
    output logic          RDY
);

    localparam int unsigned N    = 1 << LOGN;
    localparam int unsigned NDIG = (LOGR == 0) ? 1 : LOGN / LOGR;
    localparam int unsigned HALF = LOGN / 2;

    if (LOGN < 4 || LOGN > 12) begin : g_bad_logn
        $error("fft_reorder_buf: LOGN must lie in 4..12");
    end
    if (LOGR == 0 || (LOGN % LOGR) != 0) begin : g_bad_logr
        $error("fft_reorder_buf: LOGN must be a multiple of LOGR");
    end
    // Half-swap mode is always selectable at run time, so odd LOGN is rejected outright.
    if ((LOGN % 2) != 0) begin : g_bad_half
        $error("fft_reorder_buf: half-swap mode needs an even LOGN");
    end

    logic [LOGN:0]    addr_q, addr_d;
    logic             primed_q, primed_d;
    logic [1:0]       mode_q, mode_d;
    logic             vld_q, vld_d;
    logic             rdy_q, rdy_d;
    logic [NB-1:0]    dor_q, dor_d;
    logic [NB-1:0]    doi_q, doi_d;

    logic [LOGN-1:0]  wr_addr;
    logic [LOGN-1:0]  rd_addr;
    logic [LOGN-1:0]  rev_bits;
    logic [LOGN-1:0]  rev_digits;
    logic [LOGN-1:0]  swap_halves;
    logic [2*NB-1:0]  rd_word;
    logic             wr_en;

    logic [2*NB-1:0]  mem [2*N];

    assign wr_addr = addr_q[LOGN-1:0];
    assign wr_en   = ED && !START && !RST;

    always_comb begin
        rev_bits = '0;
        for (int i = 0; i < LOGN; i++) begin
            rev_bits[i] = wr_addr[LOGN-1-i];
        end
    end

    // Digit order is reversed; bit order inside each digit is preserved.
    always_comb begin
        rev_digits = '0;
        for (int d = 0; d < NDIG; d++) begin
            for (int b = 0; b < LOGR; b++) begin
                rev_digits[(NDIG-1-d)*LOGR+b] = wr_addr[d*LOGR+b];
            end
        end
    end

    assign swap_halves = {wr_addr[HALF-1:0], wr_addr[LOGN-1:HALF]};

    always_comb begin
        rd_addr = wr_addr;
        unique case (mode_q)
            2'd0: rd_addr = wr_addr;
            2'd1: rd_addr = rev_bits;
            2'd2: rd_addr = rev_digits;
            2'd3: rd_addr = swap_halves;
        endcase
    end

    // Write bank is addr_q[LOGN]; the read bank is always the opposite one.
    assign rd_word = mem[{~addr_q[LOGN], rd_addr}];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[{addr_q[LOGN], wr_addr}] <= {DR, DI};
        end
    end

    always_comb begin
        addr_d   = addr_q;
        primed_d = primed_q;
        mode_d   = mode_q;
        vld_d    = 1'b0;
        rdy_d    = 1'b0;
        dor_d    = dor_q;
        doi_d    = doi_q;
        if (START) begin
            addr_d   = '0;
            primed_d = 1'b0;
            mode_d   = MODE;
        end else if (ED) begin
            addr_d         = addr_q + 1'b1;
            {dor_d, doi_d} = rd_word;
            vld_d          = primed_q;
            rdy_d          = primed_q && (wr_addr == '0);
            if (wr_addr == '1) begin
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            primed_q <= 1'b0;
            mode_q   <= MODE;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b0;
            dor_q    <= '0;
            doi_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            primed_q <= primed_d;
            mode_q   <= mode_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
            dor_q    <= dor_d;
            doi_q    <= doi_d;
        end
    end

    assign DOR = dor_q;
    assign DOI = doi_q;
    assign VLD = vld_q;
    assign RDY = rdy_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Drives two reorder buffers (N=256 radix-16, N=64 radix-4) with shared stimulus and
// checks them against a frame-history reference model.
module tb_fft_reorder_buf;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        ED;
    logic [1:0]  MODE;
    logic [11:0] DR;
    logic [11:0] DI;

    logic [11:0] dor8, doi8, dor6, doi6;
    logic        vld8, rdy8, vld6, rdy6;

    fft_reorder_buf #(.NB(12), .LOGN(8), .LOGR(4)) u_dut8 (
        .CLK(CLK), .RST(RST), .START(START), .ED(ED), .MODE(MODE), .DR(DR), .DI(DI),
        .DOR(dor8), .DOI(doi8), .VLD(vld8), .RDY(rdy8)
    );

    fft_reorder_buf #(.NB(12), .LOGN(6), .LOGR(2)) u_dut6 (
        .CLK(CLK), .RST(RST), .START(START), .ED(ED), .MODE(MODE), .DR(DR), .DI(DI),
        .DOR(dor6), .DOI(doi6), .VLD(vld6), .RDY(rdy6)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every sample written since the last restart, in arrival order.
    logic [23:0] hist [$];
    int          e_cnt;
    int          mode_l;
    int          logn_t [2] = '{8, 6};
    int          logr_t [2] = '{4, 2};
    logic        exp_vld [2];
    logic        exp_rdy [2];
    logic [11:0] exp_dor [2];
    logic [11:0] exp_doi [2];
    bit          known   [2];
    int          vld6_seen;
    int          rdy8_at [$];
    int          ed_seen;

    function automatic int perm(input int logn, input int logr, input int m, input int k);
        int r;
        int h;
        int nd;
        r = 0;
        case (m)
            0: r = k;
            1: for (int i = 0; i < logn; i++) if (((k >> i) & 1) == 1) r += 1 << (logn - 1 - i);
            2: begin
                nd = logn / logr;
                for (int d = 0; d < nd; d++)
                    r += ((k >> (d * logr)) % (1 << logr)) << ((nd - 1 - d) * logr);
            end
            default: begin
                h = logn / 2;
                r = ((k % (1 << h)) << h) + (k >> h);
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit rst_v, input bit st_v, input bit ed_v,
                        input logic [11:0] dr_v, input logic [11:0] di_v);
        int n, j, f, k;
        logic [23:0] w;
        RST   = rst_v;
        START = st_v;
        ED    = ed_v;
        DR    = dr_v;
        DI    = di_v;
        if (rst_v) begin
            e_cnt = 0;
            hist.delete();
            mode_l = int'(MODE);
            for (int u = 0; u < 2; u++) begin
                exp_vld[u] = 1'b0; exp_rdy[u] = 1'b0;
                exp_dor[u] = '0;   exp_doi[u] = '0; known[u] = 1'b1;
            end
        end else if (st_v) begin
            e_cnt = 0;
            hist.delete();
            mode_l = int'(MODE);
            for (int u = 0; u < 2; u++) begin
                exp_vld[u] = 1'b0; exp_rdy[u] = 1'b0;
            end
        end else if (ed_v) begin
            hist.push_back({dr_v, di_v});
            e_cnt++;
            for (int u = 0; u < 2; u++) begin
                n = 1 << logn_t[u];
                if (e_cnt > n) begin
                    j = e_cnt - n - 1;
                    f = j / n;
                    k = j % n;
                    w = hist[f * n + perm(logn_t[u], logr_t[u], mode_l, k)];
                    exp_dor[u] = w[23:12];
                    exp_doi[u] = w[11:0];
                    exp_vld[u] = 1'b1;
                    exp_rdy[u] = (k == 0);
                    known[u]   = 1'b1;
                end else begin
                    exp_vld[u] = 1'b0;
                    exp_rdy[u] = 1'b0;
                    known[u]   = 1'b0;
                end
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                exp_vld[u] = 1'b0; exp_rdy[u] = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
        chk("n256 vld", int'(vld8), int'(exp_vld[0]));
        chk("n256 rdy", int'(rdy8), int'(exp_rdy[0]));
        chk("n64 vld", int'(vld6), int'(exp_vld[1]));
        chk("n64 rdy", int'(rdy6), int'(exp_rdy[1]));
        if (known[0]) begin
            chk("n256 dor", int'(dor8), int'(exp_dor[0]));
            chk("n256 doi", int'(doi8), int'(exp_doi[0]));
        end
        if (known[1]) begin
            chk("n64 dor", int'(dor6), int'(exp_dor[1]));
            chk("n64 doi", int'(doi6), int'(exp_doi[1]));
        end
        vld6_seen += int'(vld6);
        if (ed_v && !st_v && !rst_v) ed_seen++;
        if (rdy8) rdy8_at.push_back(ed_seen);
    endtask

    task automatic rnd_ed();
        step(1'b0, 1'b0, 1'b1, 12'($urandom), 12'($urandom));
    endtask

    initial begin
        int win;
        int hits;
        RST = 1'b1; START = 1'b0; ED = 1'b0; MODE = 2'd3; DR = '0; DI = '0;
        vld6_seen = 0;
        ed_seen   = 0;

        // Reset, including an ED and START that reset must override.
        step(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
        step(1'b1, 1'b1, 1'b1, 12'h123, 12'h456);

        // Half-swap, ramp input, 520 back-to-back EDs.
        step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        ed_seen = 0;
        rdy8_at.delete();
        for (int i = 0; i < 520; i++) step(1'b0, 1'b0, 1'b1, i[11:0], ~i[11:0]);
        chk("n256 rdy pulses", rdy8_at.size(), 2);
        if (rdy8_at.size() >= 2) begin
            chk("n256 first rdy ed", rdy8_at[0], 257);
            chk("n256 second rdy ed", rdy8_at[1], 513);
        end

        // Bit reversal with random idle gaps over three frames.
        MODE = 2'd1;
        step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        vld6_seen = 0;
        for (int i = 0; i < 192; i++) begin
            win = $urandom_range(0, 5);
            for (int g = 0; g < win; g++) step(1'b0, 1'b0, 1'b0, 12'($urandom), 12'h0);
            rnd_ed();
        end
        chk("n64 vld count", vld6_seen, 128);

        // Radix-4 digit reversal on a ramp.
        MODE = 2'd2;
        step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        for (int i = 0; i < 130; i++) begin
            step(1'b0, 1'b0, 1'b1, i[11:0], 12'h0);
            if (i == 65) chk("digitrev out1", int'(dor6), 16);
            if (i == 68) chk("digitrev out4", int'(dor6), 4);
        end

        // Natural order, restart mid-frame, then a full silent frame.
        MODE = 2'd0;
        step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        for (int i = 0; i < 148; i++) rnd_ed();
        step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        vld6_seen = 0;
        for (int i = 0; i < 64; i++) rnd_ed();
        chk("n64 vld after restart", vld6_seen, 0);
        for (int i = 0; i < 64; i++) rnd_ed();

        // START wins over a simultaneous ED carrying 0x5A5.
        step(1'b0, 1'b1, 1'b1, 12'h5A5, 12'h5A5);
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, 1'b1, i[11:0], 12'h0);
            if (vld6 && dor6 == 12'h5A5) hits++;
            if (i == 64) chk("n64 first out addr0", int'(dor6), 0);
        end
        chk("0x5A5 never output", hits, 0);

        // MODE change without START is ignored; RST mid-frame; MODE latched by RST.
        step(1'b0, 1'b1, 1'b0, 12'h0, 12'h0);
        for (int i = 0; i < 94; i++) rnd_ed();
        MODE = 2'd3;
        for (int i = 0; i < 40; i++) rnd_ed();
        win = $urandom_range(1, 50);
        for (int i = 0; i < win; i++) rnd_ed();
        MODE = 2'd1;
        step(1'b1, 1'b0, 1'b1, 12'($urandom), 12'($urandom));
        chk("rst dor zero", int'(dor6), 0);
        MODE = 2'd2;
        for (int i = 0; i < 140; i++) begin
            if ((i % 7) == 3) step(1'b0, 1'b0, 1'b0, 12'h0, 12'h0);
            rnd_ed();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
